fp_vector_player: RTL
=====================

FP_VECTOR_PLAYER -- requirements
Module: fp_vector_player

Interface
REQ-001 Parameter ADDR_W, 10, vector memory address width; max ADDR_W is 16.
REQ-002 Parameter TIMEOUT, 64, max cycles from dut_start to dut_done before an operation is declared failed.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a run; ignored while busy.
REQ-006 op_mode  in  2  latched at start; 00=div, 01=sqrt.
REQ-007 round_mode  in  1  latched at start; 0=rne, 1=rz.
REQ-008 vec_count  in  ADDR_W+1  number of vectors in run, latched at start.
REQ-009 vec_addr  out  ADDR_W  vector memory read address.
REQ-010 vec_rdata  in  96  {a[95:64], b[63:32], expected[31:0]}; valid one cycle after vec_addr is presented.
REQ-011 dut_op, dut_round_mode, dut_a, dut_b  out  2,1,32,32  operands to fpdiv; held stable from dut_start until dut_done.
REQ-012 dut_start  out  1  one-cycle pulse launching one operation.
REQ-013 dut_done  in  1  one-cycle pulse; dut_result valid in the same cycle.
REQ-014 dut_result  in  32  divider/sqrt result.
REQ-015 busy, done  out  1,1  run in progress; run complete (sticky until next start).
REQ-016 pass_count, fail_count  out  16,16  saturating counters.
REQ-017 first_fail_valid, first_fail_idx, first_fail_result  out  1, ADDR_W, 32  capture of first mismatch.
REQ-018 timeout_seen  out  1  sticky; any operation exceeded TIMEOUT.

Function
REQ-019 States SHALL be IDLE, FETCH, LOAD, ISSUE, WAIT, CHECK, FINISH.
REQ-020 IDLE + start: latch op_mode, round_mode, vec_count; clear counters, first_fail_*, timeout_seen, done; idx=0; go FETCH, or FINISH if vec_count=0.
REQ-021 FETCH: drive vec_addr=idx; next cycle LOAD.
REQ-022 LOAD: register a, b, expected from vec_rdata; go ISSUE. For sqrt, dut_b SHALL be driven 0.
REQ-023 ISSUE: assert dut_start for exactly one cycle; clear the timeout counter; go WAIT.
REQ-024 WAIT: on dut_done, register dut_result and go CHECK; on timeout counter reaching TIMEOUT with no dut_done, count fail, set timeout_seen, and advance as in REQ-026.
REQ-025 CHECK: the comparison SHALL be exact 32-bit equality; on match, pass_count+1; on mismatch, fail_count+1, and if first_fail_valid=0, capture idx and the result, then set first_fail_valid.
REQ-026 After CHECK: idx+1; if idx+1 == vec_count, go FINISH, otherwise go FETCH.
REQ-027 FINISH: set done for one state transition, then go IDLE; done SHALL remain 1 until the next accepted start.
REQ-028 Per-vector latency SHALL be 4 cycles + divider latency (FETCH, LOAD, ISSUE, CHECK).
REQ-029 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-030 A dut_done arriving outside WAIT SHALL be ignored.
REQ-031 A start arriving while busy SHALL be ignored, with no effect on the run.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 Reset SHALL force IDLE. All outputs SHALL be 0: busy, done, dut_start, counts, first_fail_*, timeout_seen, vec_addr, dut_*.
REQ-034 Reset mid-run SHALL abort immediately; a later dut_done SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold: the state enum; the op encodings (OP_DIV=2'b00, OP_SQRT=2'b01); the round encodings (RNE=0, RZ=1); and the vector field offsets.
REQ-036 One sub-module, fp_result_checker, SHALL handle comparison, saturating counters, and first-fail capture.

Verification
REQ-037 sqrt rz, 3 vectors, model returns expected results after 10 cycles -> pass_count=3, fail_count=0, done=1, first_fail_valid=0.
REQ-038 div rne, 4 vectors, with the vector at idx 2 returning 32'h3F800001 instead of 32'h3F800000 -> fail_count=1, first_fail_idx=2, first_fail_result=32'h3F800001.
REQ-039 vec_count=0 -> done=1 within 2 cycles of start; no dut_start pulse.
REQ-040 Model never asserts dut_done, TIMEOUT=64, 2 vectors -> fail_count=2, timeout_seen=1, done=1.
REQ-041 Reset asserted during WAIT of vector 1, then dut_done pulsed -> all outputs 0; state stays IDLE.
REQ-042 start pulsed again mid-run, plus a stray dut_done in FETCH -> run continues unaffected; final counts match REQ-037.

Source files
------------

// File: rtl/fp_vector_player_pkg.sv
// Shared types and constants for the floating-point vector player.
package fp_vector_player_pkg;

  // Sequencer states, one per step of a vector's life.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  // Operation encodings driven on dut_op.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;

  // Rounding encodings driven on dut_round_mode.
  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RZ  = 1'b1;

  // Vector word layout: {a, b, expected}, each one 32-bit float.
  localparam int VEC_W   = 96;
  localparam int FIELD_W = 32;
  localparam int A_LSB   = 64;
  localparam int B_LSB   = 32;
  localparam int EXP_LSB = 0;

  // Width of the pass/fail counters.
  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fp_vector_player_checker.sv
// Result checker: exact compare, saturating pass/fail counters, first-fail capture.
module fp_result_checker
  import fp_vector_player_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               check_en,
  input  logic               timeout_fail,
  input  logic [ADDR_W-1:0]  idx,
  input  logic [FIELD_W-1:0] result,
  input  logic [FIELD_W-1:0] expected,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic               first_fail_valid,
  output logic [ADDR_W-1:0]  first_fail_idx,
  output logic [FIELD_W-1:0] first_fail_result
);

  logic match;

  assign match = (result == expected);

  // Pass/fail tallies; a timed-out operation counts as a failure with no result to compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (check_en) begin
      if (match) pass_count <= sat_inc(pass_count);
      else       fail_count <= sat_inc(fail_count);
    end else if (timeout_fail) begin
      fail_count <= sat_inc(fail_count);
    end
  end

  // Remember only the first mismatching vector of a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_fail_valid  <= 1'b0;
      first_fail_idx    <= '0;
      first_fail_result <= '0;
    end else if (clear) begin
      first_fail_valid  <= 1'b0;
      first_fail_idx    <= '0;
      first_fail_result <= '0;
    end else if (check_en && !match && !first_fail_valid) begin
      first_fail_valid  <= 1'b1;
      first_fail_idx    <= idx;
      first_fail_result <= result;
    end
  end

endmodule

// File: rtl/fp_vector_player.sv
// Vector player: reads test vectors from memory, drives an fpdiv/sqrt unit, checks results.
module fp_vector_player
  import fp_vector_player_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op_mode,
  input  logic               round_mode,
  input  logic [ADDR_W:0]    vec_count,
  output logic [ADDR_W-1:0]  vec_addr,
  input  logic [VEC_W-1:0]   vec_rdata,
  output logic [1:0]         dut_op,
  output logic               dut_round_mode,
  output logic [FIELD_W-1:0] dut_a,
  output logic [FIELD_W-1:0] dut_b,
  output logic               dut_start,
  input  logic               dut_done,
  input  logic [FIELD_W-1:0] dut_result,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic               first_fail_valid,
  output logic [ADDR_W-1:0]  first_fail_idx,
  output logic [FIELD_W-1:0] first_fail_result,
  output logic               timeout_seen
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t             state, next_state;
  logic [ADDR_W:0]    idx, idx_inc, vec_count_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [FIELD_W-1:0] expected_q, result_q;
  logic               accept_start, last_vec, tmo_hit, check_en, timeout_fail;

  // idx is one bit wider than the address so a full-memory run can reach vec_count.
  assign idx_inc  = idx + IDX_ONE;
  assign vec_addr = idx[ADDR_W-1:0];
  assign last_vec = (idx_inc == vec_count_q);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and single-cycle strobes; start is only honoured from IDLE.
  always_comb begin
    next_state   = state;
    busy         = (state != IDLE);
    dut_start    = 1'b0;
    accept_start = 1'b0;
    check_en     = 1'b0;
    timeout_fail = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = (vec_count == '0) ? FINISH : FETCH;
        end
      end
      FETCH:  next_state = LOAD;
      LOAD:   next_state = ISSUE;
      ISSUE: begin
        dut_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (dut_done) begin
          next_state = CHECK;
        end else if (tmo_hit) begin
          timeout_fail = 1'b1;
          next_state   = last_vec ? FINISH : FETCH;
        end
      end
      CHECK: begin
        check_en   = 1'b1;
        next_state = last_vec ? FINISH : FETCH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Run configuration, operand registers, vector index, timeout tracking and run status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_op         <= '0;
      dut_round_mode <= 1'b0;
      dut_a          <= '0;
      dut_b          <= '0;
      expected_q     <= '0;
      result_q       <= '0;
      idx            <= '0;
      vec_count_q    <= '0;
      tmo_cnt        <= '0;
      done           <= 1'b0;
      timeout_seen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_start) begin
            dut_op         <= op_mode;
            dut_round_mode <= round_mode;
            vec_count_q    <= vec_count;
            idx            <= '0;
            done           <= 1'b0;
            timeout_seen   <= 1'b0;
          end
        end
        LOAD: begin
          dut_a      <= vec_rdata[A_LSB +: FIELD_W];
          dut_b      <= (dut_op == OP_SQRT) ? '0 : vec_rdata[B_LSB +: FIELD_W];
          expected_q <= vec_rdata[EXP_LSB +: FIELD_W];
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (dut_done) begin
            result_q <= dut_result;
          end else if (tmo_hit) begin
            timeout_seen <= 1'b1;
            idx          <= idx_inc;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        CHECK:  idx  <= idx_inc;
        FINISH: done <= 1'b1;
        default: ;
      endcase
    end
  end

  fp_result_checker #(
    .ADDR_W(ADDR_W)
  ) u_checker (
    .clk              (clk),
    .reset            (reset),
    .clear            (accept_start),
    .check_en         (check_en),
    .timeout_fail     (timeout_fail),
    .idx              (idx[ADDR_W-1:0]),
    .result           (result_q),
    .expected         (expected_q),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .first_fail_result(first_fail_result)
  );

endmodule
